// File: rtl/dp_ram_be_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dp_ram_be_if : write/read port bundle for dp_ram_be                   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface dp_ram_be_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  logic                  we_i;
  logic [WIDTH/8-1:0]    wbe_i;
  logic [ADDR_W-1:0]     waddr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic                  re_i;
  logic [ADDR_W-1:0]     raddr_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  rvalid_o;
  logic                  busy_o;

  modport master (
    output we_i, wbe_i, waddr_i, wdata_i, re_i, raddr_i,
    input  rdata_o, rvalid_o, busy_o
  );

  modport slave (
    input  we_i, wbe_i, waddr_i, wdata_i, re_i, raddr_i,
    output rdata_o, rvalid_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/dp_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dp_ram_be : 1R1W RAM with byte enables, self-clear after reset and    |
// | READ_LAT (1|2) read pipeline. DP_RAM_BYPASS_EN selects write-first.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dp_ram_be #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dp_ram_be_if.slave bus
);

  localparam int c_NBYTES = WIDTH / 8;
  localparam int c_DEPTH  = 1 << ADDR_W;

  localparam logic [0:0] c_ST_CLEAR = 1'b0;
  localparam logic [0:0] c_ST_READY = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [WIDTH-1:0]  r_mem [c_DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [WIDTH-1:0]  w_rd_old;
  logic [WIDTH-1:0]  w_rd_word;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_rvalid;

  if (WIDTH % 8 != 0) begin : g_bad_width
    $error("dp_ram_be: WIDTH must be a multiple of 8");
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_CLEAR: if (r_clr_addr == {ADDR_W{1'b1}}) w_state_nxt = c_ST_READY;
      default:    w_state_nxt = c_ST_READY;
    endcase
  end

  // Output decode: user requests are only honoured once the clear sweep is done
  always_comb begin
    w_busy   = 1'b0;
    w_clr_we = 1'b0;
    w_wr_en  = 1'b0;
    w_rd_en  = 1'b0;
    case (r_state)
      c_ST_CLEAR: begin
        w_busy   = 1'b1;
        w_clr_we = 1'b1;
      end
      default: begin
        w_wr_en = bus.we_i;
        w_rd_en = bus.re_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_clr_addr <= '0;
    end else if (r_state == c_ST_CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // Storage has no reset; the clear sweep initialises it
  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < c_NBYTES; k++) begin
        if (bus.wbe_i[k]) r_mem[bus.waddr_i][8*k +: 8] <= bus.wdata_i[8*k +: 8];
      end
    end
  end

  assign w_rd_old = r_mem[bus.raddr_i];

`ifdef DP_RAM_BYPASS_EN
  logic [WIDTH-1:0] w_be_mask;
  for (genvar k = 0; k < c_NBYTES; k++) begin : g_be_mask
    assign w_be_mask[8*k +: 8] = {8{bus.wbe_i[k]}};
  end
  assign w_rd_word = (w_wr_en && (bus.waddr_i == bus.raddr_i))
                   ? ((w_rd_old & ~w_be_mask) | (bus.wdata_i & w_be_mask))
                   : w_rd_old;
`else
  assign w_rd_word = w_rd_old;
`endif

  if (READ_LAT == 1) begin : g_lat1
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_rd_en;
        if (w_rd_en) r_rdata <= w_rd_word;
      end
    end
  end else if (READ_LAT == 2) begin : g_lat2
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_s1_valid <= 1'b0;
        r_s1_data  <= '0;
        r_rvalid   <= 1'b0;
        r_rdata    <= '0;
      end else begin
        r_s1_valid <= w_rd_en;
        if (w_rd_en) r_s1_data <= w_rd_word;
        r_rvalid <= r_s1_valid;
        if (r_s1_valid) r_rdata <= r_s1_data;
      end
    end
  end else begin : g_bad_lat
    $error("dp_ram_be: READ_LAT must be 1 or 2");
  end

  assign bus.rdata_o  = r_rdata;
  assign bus.rvalid_o = r_rvalid;
  assign bus.busy_o   = w_busy;

endmodule

`default_nettype wire
